// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: one arbitrated stall/flush command per cycle, plus a multi-cycle MDU sequencer.
// Optional feature macro HAZARD_PERF_EN: when defined, the stall-cycle and flush counters are real counters.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_busy,
  input  logic        dbus_busy,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_redirect,
  input  logic        ex_mdu_start,
  input  logic        wb_trap,
  output logic [2:0]  stall,
  output logic [1:0]  flush,
  output logic        mdu_busy,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
);

  localparam int CW = 7;

  typedef enum logic [1:0] {IDLE, MDU_WAIT, MDU_DONE, TRAP_PEND} state_t;
  typedef enum logic [2:0] {S_NONE, S_F, S_D, S_E, S_W} stall_t;
  typedef enum logic [1:0] {F_NONE, F_D, F_M, F_W} flush_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_dec;
  stall_t        stall_c;
  flush_t        flush_c;
  logic          busy_c;
  logic          load_use;

  assign load_use = ex_load && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign cnt_dec  = cnt - CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The first matching branch wins; lower-priority hazards are simply not looked at.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = S_NONE;
    flush_c   = F_NONE;
    busy_c    = (state == MDU_WAIT);
    if (wb_trap || state == TRAP_PEND) begin
      cnt_nxt = '0;
      if (dbus_busy) begin
        stall_c   = S_W;
        state_nxt = TRAP_PEND;
      end else begin
        flush_c   = F_W;
        state_nxt = IDLE;
      end
    end else if (dbus_busy) begin
      stall_c = S_W;
    end else if (state == MDU_WAIT) begin
      // The start cycle counts as the first of MDU_LAT busy cycles.
      stall_c = S_E;
      cnt_nxt = cnt_dec;
      if (cnt_dec == '0) state_nxt = MDU_DONE;
    end else if (state == IDLE && ex_mdu_start) begin
      stall_c   = S_E;
      busy_c    = 1'b1;
      cnt_nxt   = CW'(MDU_LAT - 1);
      state_nxt = MDU_WAIT;
    end else begin
      if (state == MDU_DONE) state_nxt = IDLE;
      if (ex_redirect)    flush_c = F_D;
      else if (load_use)  stall_c = S_D;
      else if (ibus_busy) stall_c = S_F;
    end
  end

  assign stall    = reset ? 3'd0 : stall_c;
  assign flush    = reset ? 2'd0 : flush_c;
  assign mdu_busy = reset ? 1'b0 : busy_c;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall != 3'd0) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (flush != 2'd0) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cyc = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MDU_LAT=4): stateless vector table plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset, ibus_busy, dbus_busy, ex_load, ex_redirect, ex_mdu_start, wb_trap;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [2:0] stall;
  logic [1:0] flush;
  logic mdu_busy;
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(4)) dut (
    .clk(clk), .reset(reset), .ibus_busy(ibus_busy), .dbus_busy(dbus_busy),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_load(ex_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start), .wb_trap(wb_trap),
    .stall(stall), .flush(flush), .mdu_busy(mdu_busy),
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
  );

  typedef struct {
    logic ib, db, ld, redir, trap;
    logic [4:0] rs1, rs2, rd;
    int st, fl;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    ibus_busy = 0; dbus_busy = 0; ex_load = 0; ex_redirect = 0;
    ex_mdu_start = 0; wb_trap = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Check outputs at the falling edge, then advance past the next rising edge.
  task automatic cyc(input string nm, input int s, input int f, input int b);
    @(negedge clk);
    chk({nm, ".stall"}, int'(stall), s);
    chk({nm, ".flush"}, int'(flush), f);
    chk({nm, ".mdu_busy"}, int'(mdu_busy), b);
    tick();
  endtask

  initial begin
    //      ib db ld rd trap rs1 rs2 rd st fl
    vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[2] = '{0, 0, 1, 0, 0, 1, 5, 5, 2, 0};
    vt[3] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[4] = '{1, 0, 1, 0, 0, 7, 2, 7, 2, 0};
    vt[5] = '{0, 0, 1, 1, 0, 3, 5, 5, 0, 1};
    vt[6] = '{0, 1, 1, 1, 0, 5, 0, 5, 4, 0};
    vt[7] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 3};
    vt[8] = '{0, 0, 1, 0, 0, 4, 6, 3, 0, 0};
    vt[9] = '{0, 0, 0, 0, 0, 5, 5, 5, 0, 0};

    idle_in();
    reset = 1;
    tick();
    ibus_busy = 1; wb_trap = 1;
    cyc("rst_force", 0, 0, 0);
    chk("rst_perf_s", int'(perf_stall_cyc), 0);
    chk("rst_perf_f", int'(perf_flush_cnt), 0);
    idle_in();
    reset = 0;

    for (int i = 0; i < 10; i++) begin
      ibus_busy = vt[i].ib; dbus_busy = vt[i].db; ex_load = vt[i].ld;
      ex_redirect = vt[i].redir; wb_trap = vt[i].trap;
      id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; ex_rd = vt[i].rd;
      cyc($sformatf("vec%0d", i), vt[i].st, vt[i].fl, 0);
    end
    idle_in();

    // MDU with start held through the whole operation and the done cycle
    ex_mdu_start = 1;
    cyc("mdu1", 3, 0, 1);
    cyc("mdu2", 3, 0, 1);
    cyc("mdu3", 3, 0, 1);
    cyc("mdu4", 3, 0, 1);
    cyc("mdu_done", 0, 0, 0);
    ex_mdu_start = 0;
    cyc("mdu_norestart", 0, 0, 0);

    // MDU frozen by dbus, outranks redirect, done cycle lets load-use through
    ex_mdu_start = 1;
    cyc("mfz1", 3, 0, 1);
    ex_mdu_start = 0; dbus_busy = 1;
    cyc("mfz_dbus", 4, 0, 1);
    dbus_busy = 0; ex_redirect = 1;
    cyc("mfz2_redir", 3, 0, 1);
    ex_redirect = 0;
    cyc("mfz3", 3, 0, 1);
    cyc("mfz4", 3, 0, 1);
    ex_load = 1; ex_rd = 9; id_rs1 = 9;
    cyc("mfz_done_lu", 2, 0, 0);
    idle_in();
    cyc("mfz_idle", 0, 0, 0);

    // Trap while the data bus is busy
    wb_trap = 1; dbus_busy = 1;
    cyc("tp1", 4, 0, 0);
    wb_trap = 0;
    cyc("tp2", 4, 0, 0);
    cyc("tp3", 4, 0, 0);
    dbus_busy = 0;
    cyc("tp_flush", 0, 3, 0);
    cyc("tp_after", 0, 0, 0);

    // Trap on MDU cycle 2 aborts it
    ex_mdu_start = 1;
    cyc("mtr1", 3, 0, 1);
    ex_mdu_start = 0; wb_trap = 1;
    cyc("mtr_trap", 0, 3, 1);
    wb_trap = 0;
    cyc("mtr_abort", 0, 0, 0);
    cyc("mtr_after", 0, 0, 0);

    // Reset mid-MDU and mid-TRAP_PEND
    ex_mdu_start = 1;
    cyc("rm1", 3, 0, 1);
    ex_mdu_start = 0; reset = 1;
    cyc("rm_rst", 0, 0, 0);
    reset = 0;
    cyc("rm_after", 0, 0, 0);
    wb_trap = 1; dbus_busy = 1;
    cyc("rt1", 4, 0, 0);
    wb_trap = 0; reset = 1;
    cyc("rt_rst", 0, 0, 0);
    reset = 0; dbus_busy = 0;
    cyc("rt_noflush", 0, 0, 0);

    // Performance counters: 5 stall cycles then 2 flush cycles after a fresh reset
    reset = 1;
    tick();
    reset = 0;
    ibus_busy = 1;
    for (int i = 0; i < 5; i++) tick();
    ibus_busy = 0; ex_redirect = 1;
    for (int i = 0; i < 2; i++) tick();
    ex_redirect = 0;
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk("perf_stall", int'(perf_stall_cyc), 5);
    chk("perf_flush", int'(perf_flush_cnt), 2);
`else
    chk("perf_stall", int'(perf_stall_cyc), 0);
    chk("perf_flush", int'(perf_flush_cnt), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
